// File: rtl/conv_enc_pkg.sv
// rtl/conv_enc_pkg.sv - K=3 rate-1/2 code constants, FSM states and symbol function
// CONV_ENC_TAIL_EN adds the TAIL state for zero-tail termination.
package conv_enc_pkg;

  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
`ifdef CONV_ENC_TAIL_EN
    TAIL   = 2'd2,
`endif
    FLUSH  = 2'd3
  } state_t;

  // Tap vector is {newest bit, sr[1], sr[0]}; MSB of each generator taps the newest bit.
  function automatic logic [1:0] conv_symbol(input logic code_bit, input logic [K-2:0] sr);
    logic [K-1:0] taps;
    taps = {code_bit, sr};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// rtl/conv_enc_core.sv - encoder shift register and generator logic (combinational symbol)
module conv_enc_core
  import conv_enc_pkg::*;
(
  input  logic       clk,
  input  logic       RSTn,
  input  logic       code_bit,
  input  logic       shift_en,
  input  logic       clear,
  output logic [1:0] sym
);

  logic [K-2:0] sr;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= {code_bit, sr[K-2:1]};
    end
  end

  assign sym = conv_symbol(code_bit, sr);

endmodule

// File: rtl/conv_encoder_top.sv
// rtl/conv_encoder_top.sv - framed convolutional encoder: FSM, bit counter, output registers
// Define CONV_ENC_TAIL_EN to terminate every frame with two zero tail bits.
module conv_encoder_top
  import conv_enc_pkg::*;
#(
  parameter int FRAME_MAX = 128
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       d_in_valid,
  input  logic       d_in,
  output logic       d_in_ready,
  output logic       d_out_valid,
  output logic [1:0] d_out,
  output logic       frame_start,
  output logic       frame_end,
  output logic [7:0] bit_cnt
);

  localparam logic [7:0] CNT_MAX = 8'(FRAME_MAX);

  state_t     state;
  logic       xfer;
  logic       shift_en;
  logic       code_bit;
  logic       clear;
  logic [1:0] sym;

  assign xfer     = d_in_valid && d_in_ready;
  assign code_bit = d_in & xfer;
  assign clear    = (state == FLUSH);

`ifdef CONV_ENC_TAIL_EN
  logic tail_second;
  // The frame-ending ENCODE cycle already feeds the first zero, so tail symbols follow data without a gap.
  assign shift_en = xfer || (state == ENCODE) || (state == TAIL && !tail_second);
`else
  assign shift_en = xfer;
`endif

  conv_enc_core u_core (
    .clk      (clk),
    .RSTn     (RSTn),
    .code_bit (code_bit),
    .shift_en (shift_en),
    .clear    (clear),
    .sym      (sym)
  );

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      d_out       <= '0;
      d_out_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      d_in_ready  <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
      tail_second <= 1'b0;
`endif
    end else begin
      d_out_valid <= shift_en;
      if (shift_en) d_out <= sym;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      case (state)
        IDLE: begin
          d_in_ready <= 1'b1;
          if (xfer) begin
            state       <= ENCODE;
            bit_cnt     <= 8'd1;
            frame_start <= 1'b1;
          end
        end
        ENCODE: begin
          if (xfer) begin
            bit_cnt    <= bit_cnt + 8'd1;
            d_in_ready <= (bit_cnt + 8'd1 != CNT_MAX);
          end else begin
            d_in_ready <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
            state       <= TAIL;
            tail_second <= 1'b0;
`else
            state     <= FLUSH;
            frame_end <= 1'b1;
`endif
          end
        end
`ifdef CONV_ENC_TAIL_EN
        TAIL: begin
          tail_second <= 1'b1;
          if (tail_second) begin
            state     <= FLUSH;
            frame_end <= 1'b1;
          end
        end
`endif
        FLUSH: begin
          state      <= IDLE;
          d_in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_top.sv
// tb/tb_conv_encoder_top.sv - directed and randomized bench for conv_encoder_top with FRAME_MAX=4
// Follows CONV_ENC_TAIL_EN to select the expected frame termination.
module tb_conv_encoder_top;

  localparam int FMAX = 4;
`ifdef CONV_ENC_TAIL_EN
  localparam int NTAIL = 2;
`else
  localparam int NTAIL = 0;
`endif
  localparam int RST_AT = (NTAIL > 0) ? 5 : 2;

  logic       clk = 1'b0;
  logic       RSTn = 1'b0;
  logic       d_in_valid = 1'b0;
  logic       d_in = 1'b0;
  logic       d_in_ready;
  logic       d_out_valid;
  logic [1:0] d_out;
  logic       frame_start;
  logic       frame_end;
  logic [7:0] bit_cnt;

  int checks = 0;
  int failures = 0;
  bit         src[$];
  logic [1:0] obs[$];
  logic [1:0] lit[$];

  always #5 clk = ~clk;

  conv_encoder_top #(.FRAME_MAX(FMAX)) dut (
    .clk         (clk),
    .RSTn        (RSTn),
    .d_in_valid  (d_in_valid),
    .d_in        (d_in),
    .d_in_ready  (d_in_ready),
    .d_out_valid (d_out_valid),
    .d_out       (d_out),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .bit_cnt     (bit_cnt)
  );

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Symbol for input u0 with the two previous inputs u1, u2: G0 = 1+D+D^2, G1 = 1+D^2.
  function automatic logic [1:0] ref_sym(input bit u0, input bit u1, input bit u2);
    return {u0 ^ u1 ^ u2, u0 ^ u2};
  endfunction

  // Offers src with valid held high, then drops valid; checks every symbol and frame marker.
  task automatic run_burst(input string tag);
    logic [1:0] exp_sym[$];
    bit is_first[$];
    bit is_last[$];
    int chunk[$];
    int idx = 0;
    int pos = 0;
    int si = 0;
    int cur_si;
    int prev_si = -1;
    int fe_seen = 0;
    int cyc = 0;
    int fe_cyc = -100;
    obs.delete();
    while (idx < src.size()) begin
      int n;
      n = (src.size() - idx < FMAX) ? src.size() - idx : FMAX;
      chunk.push_back(n);
      for (int k = 0; k < n + NTAIL; k++) begin
        bit u0, u1, u2;
        u0 = (k < n) ? src[idx + k] : 1'b0;
        u1 = (k >= 1 && k - 1 < n) ? src[idx + k - 1] : 1'b0;
        u2 = (k >= 2 && k - 2 < n) ? src[idx + k - 2] : 1'b0;
        exp_sym.push_back(ref_sym(u0, u1, u2));
        is_first.push_back(k == 0);
        is_last.push_back(k == n + NTAIL - 1);
      end
      idx += n;
    end
    while (!(pos == src.size() && fe_seen == chunk.size()) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      cur_si = -1;
      if (d_out_valid === 1'b1) begin
        obs.push_back(d_out);
        if (si < exp_sym.size()) begin
          check({tag, ":sym"}, d_out, exp_sym[si]);
          check({tag, ":frame_start"}, frame_start, is_first[si]);
          if (is_first[si] && si > 0) check({tag, ":restart_gap"}, cyc - fe_cyc, 2);
        end else begin
          check({tag, ":sym_count"}, si + 1, exp_sym.size());
        end
        cur_si = si;
        si++;
      end else begin
        check({tag, ":frame_start_idle"}, frame_start, 1'b0);
      end
      if (frame_end === 1'b1) begin
        check({tag, ":fe_after_last"}, (prev_si >= 0 && prev_si < is_last.size()) ? is_last[prev_si] : 1'b0, 1'b1);
        check({tag, ":fe_valid_low"}, d_out_valid, 1'b0);
        check({tag, ":fe_ready_low"}, d_in_ready, 1'b0);
        if (fe_seen < chunk.size()) check({tag, ":bit_cnt"}, bit_cnt, chunk[fe_seen]);
        fe_seen++;
        fe_cyc = cyc;
      end
      prev_si = cur_si;
      d_in_valid = (pos < src.size());
      d_in = d_in_valid ? src[pos] : 1'b0;
      if (d_in_valid && d_in_ready) pos++;
    end
    d_in_valid = 1'b0;
    check({tag, ":accepted"}, pos, src.size());
    check({tag, ":frames"}, fe_seen, chunk.size());
    check({tag, ":symbols"}, si, exp_sym.size());
    @(negedge clk);
    check({tag, ":sr_idle"}, dut.u_core.sr, 2'b00);
    check({tag, ":bit_cnt_hold"}, bit_cnt, chunk.size() > 0 ? chunk[chunk.size() - 1] : 0);
  endtask

  task automatic check_lit(input string tag);
    check({tag, ":lit_count"}, obs.size(), lit.size());
    for (int i = 0; i < lit.size() && i < obs.size(); i++) check({tag, ":lit_sym"}, obs[i], lit[i]);
  endtask

  initial begin : main
    int seen;
    int pos;
    int cyc;

    #1;
    check("rst:d_in_ready", d_in_ready, 1'b0);
    check("rst:d_out_valid", d_out_valid, 1'b0);
    check("rst:d_out", d_out, 2'b00);
    check("rst:bit_cnt", bit_cnt, 8'd0);
    repeat (2) @(negedge clk);
    RSTn = 1'b1;
    #1 check("rst:ready_before_clk", d_in_ready, 1'b0);
    @(negedge clk);
    check("rst:ready_after_clk", d_in_ready, 1'b1);

    src = '{1'b1, 1'b0, 1'b1, 1'b1};
    run_burst("bits1011");
`ifdef CONV_ENC_TAIL_EN
    lit = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
`else
    lit = '{2'b11, 2'b10, 2'b00, 2'b01};
`endif
    check_lit("bits1011");
    check("bits1011:bit_cnt4", bit_cnt, 8'd4);

    src = '{1'b1};
    run_burst("single");
`ifdef CONV_ENC_TAIL_EN
    lit = '{2'b11, 2'b10, 2'b11};
`else
    lit = '{2'b11};
`endif
    check_lit("single");
    check("single:bit_cnt1", bit_cnt, 8'd1);

    src.delete();
    repeat (6) src.push_back(1'($urandom_range(0, 1)));
    run_burst("max6");

    for (int r = 0; r < 8; r++) begin
      src.delete();
      repeat ($urandom_range(1, 11)) src.push_back(1'($urandom_range(0, 1)));
      run_burst("rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    src = '{1'b1, 1'b1, 1'b0};
    seen = 0;
    pos = 0;
    cyc = 0;
    while (seen < RST_AT && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (d_out_valid === 1'b1) seen++;
      if (seen < RST_AT) begin
        d_in_valid = (pos < src.size());
        d_in = d_in_valid ? src[pos] : 1'b0;
        if (d_in_valid && d_in_ready) pos++;
      end
    end
    check("midrst:reached", seen, RST_AT);
    d_in_valid = 1'b0;
    RSTn = 1'b0;
    #1;
    check("midrst:d_out_valid", d_out_valid, 1'b0);
    check("midrst:d_out", d_out, 2'b00);
    check("midrst:frame_start", frame_start, 1'b0);
    check("midrst:frame_end", frame_end, 1'b0);
    check("midrst:d_in_ready", d_in_ready, 1'b0);
    check("midrst:bit_cnt", bit_cnt, 8'd0);
    check("midrst:sr", dut.u_core.sr, 2'b00);
    @(negedge clk);
    RSTn = 1'b1;
    #1 check("midrst:fe_release", frame_end, 1'b0);
    @(negedge clk);
    check("midrst:ready_up", d_in_ready, 1'b1);
    check("midrst:no_fe", frame_end, 1'b0);

    src.delete();
    repeat (5) src.push_back(1'($urandom_range(0, 1)));
    run_burst("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
